operand_regfile: RTL

Integer register file and operand-select stage sitting directly upstream of the ALU. It holds x1..x31 with x0 hardwired to zero, provides two combinational read ports, and writes back the ALU or load result on the clock edge. It drives the ALU dataA/dataB operands through operand muxes (rs1/PC/zero for A, rs2/immediate for B). It also exposes raw rs1/rs2 values for the store-data and branch paths.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/operand_regfile_reg_array.sv | 43 ++++
 rtl/operand_regfile.sv | 81 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, register index width, operand
// select encodings and the ALU operation codes used by decoder, regfile, ALU.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] A_SEL_RS1  = 2'b00;
  localparam logic [1:0] A_SEL_PC   = 2'b01;
  localparam logic [1:0] A_SEL_ZERO = 2'b10;

  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } alu_op_e;

endpackage

// File: rtl/operand_regfile_reg_array.sv
// Architectural register storage with one write port and two combinational
// read ports. Index 0 and indices beyond NREGS always read as zero and are
// never written.
module reg_array #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]               wdata,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] raddr1,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]               rdata1,
  output logic [XLEN-1:0]               rdata2
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_ok;

  assign wr_ok = we && (waddr != '0) && (32'(waddr) < NREGS);

  // Storage: async clear of every entry; entry 0 is never written so it stays 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  // Raw read ports with the x0 and out-of-range rules applied.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0 && 32'(raddr1) < NREGS) rdata1 = regs[raddr1[AW-1:0]];
    if (raddr2 != '0 && 32'(raddr2) < NREGS) rdata2 = regs[raddr2[AW-1:0]];
  end

endmodule

// File: rtl/operand_regfile.sv
// Register file plus operand-select stage in front of the ALU. Wraps the
// storage array, adds optional same-cycle write bypass and the A/B muxes.
module operand_regfile #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] rs1_addr,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] rs2_addr,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] rd_addr,
  input  logic                          rd_we,
  input  logic [XLEN-1:0]               rd_data,
  input  logic                          stall,
  input  logic [XLEN-1:0]               imm,
  input  logic [XLEN-1:0]               pc,
  input  logic [1:0]                    a_sel,
  input  logic                          b_sel,
  output logic [XLEN-1:0]               rs1_data,
  output logic [XLEN-1:0]               rs2_data,
  output logic [XLEN-1:0]               dataA,
  output logic [XLEN-1:0]               dataB
);

  import cpu_pkg::*;

  logic            wr_qual;
  logic [XLEN-1:0] raw1;
  logic [XLEN-1:0] raw2;

  // A write only counts when it will actually land in a real register, so
  // the bypass never forwards a value the array would discard.
  assign wr_qual = rd_we && !stall && !reset && (rd_addr != '0) && (32'(rd_addr) < NREGS);

  reg_array #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_reg_array (
    .clk    (clk),
    .reset  (reset),
    .we     (wr_qual),
    .waddr  (rd_addr),
    .wdata  (rd_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (raw1),
    .rdata2 (raw2)
  );

  // Read values: forced to zero in reset, otherwise stored value or bypassed write.
  always_comb begin
    rs1_data = raw1;
    rs2_data = raw2;
    if (reset) begin
      rs1_data = '0;
      rs2_data = '0;
    end else if (BYPASS && wr_qual) begin
      if (rd_addr == rs1_addr) rs1_data = rd_data;
      if (rd_addr == rs2_addr) rs2_data = rd_data;
    end
  end

  // Operand A mux; the reserved code behaves like the zero select.
  always_comb begin
    dataA = '0;
    case (a_sel)
      A_SEL_RS1:  dataA = rs1_data;
      A_SEL_PC:   dataA = pc;
      A_SEL_ZERO: dataA = '0;
      default:    dataA = '0;
    endcase
  end

  // Operand B mux.
  always_comb begin
    dataB = rs2_data;
    if (b_sel == B_SEL_IMM) dataB = imm;
  end

endmodule
